avalon_copy_host: RTL and testbench
===================================

AVALON_COPY_HOST -- requirements
Module: avalon_copy_host

Interface
Parameters:
REQ-001 The block SHALL take parameter ADDR_W, default 8: Avalon word-address width; matches the agent RAM_ADD_W.
REQ-002 The block SHALL take parameter LEN_W, default 9: width of the word-count field.
Ports:
REQ-003 The block SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle command strobe.
REQ-006 The block SHALL have port src_addr  input  ADDR_W  first source word address.
REQ-007 The block SHALL have port dst_addr  input  ADDR_W  first destination word address.
REQ-008 The block SHALL have port length  input  LEN_W  number of 32-bit words to copy.
REQ-009 The block SHALL have port busy  output  1  a copy is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when a copy finishes.
REQ-011 The block SHALL have port words_done  output  LEN_W  count of words written in the current or last copy.
REQ-012 The block SHALL have port address  output  ADDR_W  Avalon host word address.
REQ-013 The block SHALL have port read  output  1  Avalon read request.
REQ-014 The block SHALL have port write  output  1  Avalon write request.
REQ-015 The block SHALL have port writedata  output  32  Avalon write data.
REQ-016 The block SHALL have port byteenable  output  4  Avalon byte enables.
REQ-017 The block SHALL have port readdata  input  32  Avalon read data.
REQ-018 The block SHALL have port readdatavalid  input  1  Avalon read data qualifier.
REQ-019 The block SHALL have port waitrequest  input  1  Avalon agent stall.

Function
REQ-020 The block SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-021 In IDLE, start=1 with length>0 SHALL latch src_addr, dst_addr and length, clear words_done, and move to RD_REQ.
REQ-022 In IDLE, start=1 with length=0 SHALL move to DONE with no bus activity.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 In RD_REQ, the block SHALL drive read=1 and address=current source address.
  - read and address are held stable while waitrequest=1.
  - A read is accepted in a cycle where read=1 and waitrequest=0; the next state is then RD_WAIT.
REQ-025 In RD_WAIT, read SHALL be 0.
  - The first cycle with readdatavalid=1 captures readdata into a 32-bit holding register and moves to WR_REQ.
  - Wait time in RD_WAIT is unbounded.
REQ-026 In WR_REQ, the block SHALL drive write=1, address=current destination address, writedata=holding register and byteenable=4'hF.
  - All are held stable while waitrequest=1.
  - The write is accepted in a cycle where write=1 and waitrequest=0.
REQ-027 On write acceptance, the block SHALL increment words_done and both addresses by 1.
  - If the incremented words_done equals the latched length, the next state is DONE; otherwise it is RD_REQ.
REQ-028 Address increments SHALL wrap modulo 2**ADDR_W.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be 1 in RD_REQ, RD_WAIT and WR_REQ, and 0 in IDLE and DONE.
REQ-031 read and write SHALL never be 1 in the same cycle.
REQ-032 At most one read SHALL be outstanding at any time.
REQ-033 readdatavalid SHALL be ignored outside RD_WAIT.
REQ-034 In IDLE and DONE, address, writedata and byteenable SHALL be 0.
REQ-035 Copy throughput against a zero-wait agent with 1-cycle read latency SHALL be one word per 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
REQ-036 Overlapping source and destination ranges SHALL be copied strictly in ascending word order, with no hazard detection.

Reset
REQ-037 reset=1 on a clock edge SHALL force IDLE, with read=0, write=0, busy=0, done=0, words_done=0, address=0, writedata=0, byteenable=0, and the holding register cleared.
REQ-038 Reset asserted mid-copy SHALL abandon the transfer in the next cycle, with no further bus requests and no done pulse.
REQ-039 reset SHALL take priority over start in the same cycle.

Verification
REQ-040 The bench SHALL cover a basic copy: preload BRAM words 0..3 = 0x11111111..0x44444444, then start with src=0, dst=16, length=4 -> words 16..19 hold the same data, done pulses once, words_done=4, busy for exactly 12 cycles.
REQ-041 The bench SHALL cover zero length: start with length=0 -> done=1 on the next cycle, and read and write never asserted.
REQ-042 The bench SHALL cover waitrequest stall: agent holds waitrequest=1 for 3 cycles while read=1 -> address and read stay stable, exactly one read is accepted, and the copy completes correctly.
REQ-043 The bench SHALL cover address wrap: ADDR_W=8, src=254, dst=10, length=4 -> source words 254, 255, 0, 1 are copied to destination words 10..13.
REQ-044 The bench SHALL cover start while busy: a second start pulse mid-copy -> it is ignored, latched parameters are unchanged, and exactly one done pulse occurs.
REQ-045 The bench SHALL cover reset mid-copy: reset asserted in WR_REQ of word 2 of 8 -> outputs return to reset values the next cycle, no done pulse, and a fresh start afterwards copies correctly.

Source files
------------

// File: rtl/avalon_copy_host_if.sv
// Avalon-MM host-side bus bundle used by the word-copy engine.
// A request (read or write) is taken by the agent on a cycle where it is high and waitrequest is low;
// the host holds the request and its address/data stable while waitrequest is high.
// readdatavalid qualifies readdata for exactly one cycle per accepted read.
interface avalon_copy_host_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output readdatavalid,
        output waitrequest
    );
endinterface

// File: rtl/avalon_copy_host.sv
// Single-outstanding Avalon-MM copy engine: reads one word, writes it, advances both addresses.
// Words move strictly in ascending order; overlapping ranges are not detected.
module avalon_copy_host #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [2:0]        state_dbg,
    avalon_copy_host_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  words_done_q;
    logic [LEN_W-1:0]  words_done_inc;
    logic [31:0]       hold_q;

    logic              rd_accept;
    logic              wr_accept;

    assign words_done_inc = words_done_q + LEN_W'(1);
    assign rd_accept      = (state_q == RD_REQ) && !bus.waitrequest;
    assign wr_accept      = (state_q == WR_REQ) && !bus.waitrequest;

    // Next-state and bus outputs; everything on the bus is a pure function of state and
    // registered datapath, so requests stay stable for as long as the agent stalls.
    always_comb begin
        state_d        = state_q;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = 4'h0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                busy        = 1'b1;
                bus.read    = 1'b1;
                bus.address = src_q;
                if (rd_accept) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (bus.readdatavalid) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                busy           = 1'b1;
                bus.write      = 1'b1;
                bus.address    = dst_q;
                bus.writedata  = hold_q;
                bus.byteenable = 4'hF;
                if (wr_accept) begin
                    state_d = (words_done_inc == len_q) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; start is only looked at in IDLE, so a mid-copy pulse is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            hold_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        words_done_q <= '0;
                        if (length != '0) begin
                            src_q <= src_addr;
                            dst_q <= dst_addr;
                            len_q <= length;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.readdatavalid) begin
                        hold_q <= bus.readdata;
                    end
                end
                WR_REQ: begin
                    if (wr_accept) begin
                        words_done_q <= words_done_inc;
                        src_q        <= src_q + ADDR_W'(1);
                        dst_q        <= dst_q + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign words_done = words_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_avalon_copy_host.sv
// Directed bench for avalon_copy_host against a 256-word zero-wait BRAM agent with 1-cycle read latency.
module tb_avalon_copy_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [8:0] words_done;
    logic [2:0] state_dbg;

    avalon_copy_host_if #(.ADDR_W(8)) bus ();

    avalon_copy_host #(.ADDR_W(8), .LEN_W(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .state_dbg  (state_dbg),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Agent model and event counters
    logic [31:0] mem [256];
    logic [31:0] rdata = '0;
    logic        rdv = 1'b0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          stall_set = 0;
    int          stall_used = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_done = 0;
    int          n_busy = 0;
    int          n_both = 0;

    assign bus.readdata      = rdata;
    assign bus.readdatavalid = rdv;
    assign bus.waitrequest   = bus.read && (stall_used < stall_set);

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.read && bus.waitrequest) stall_used <= stall_used + 1;
        if (bus.read && !bus.waitrequest) begin
            rdv   <= 1'b1;
            rdata <= mem[bus.address];
            n_rd  <= n_rd + 1;
        end
        if (bus.write && !bus.waitrequest) begin
            mem[bus.address] <= bus.writedata;
            n_wr <= n_wr + 1;
        end
        if (done) n_done <= n_done + 1;
        if (busy) n_busy <= n_busy + 1;
        if (bus.read && bus.write) n_both <= n_both + 1;
    end

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a[7:0];
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic pulse_start(input int s, input int d, input int len);
        start    = 1'b1;
        src_addr = s[7:0];
        dst_addr = d[7:0];
        length   = len[8:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int b_rd, b_wr, b_done, b_busy, n;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        tick();
        tick();

        // Reset state, with a simultaneous start that reset must override
        start  = 1'b1;
        length = 9'd4;
        tick();
        start  = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst read", {31'd0, bus.read}, 32'd0);
        check("rst write", {31'd0, bus.write}, 32'd0);
        check("rst words_done", {23'd0, words_done}, 32'd0);
        check("rst address", {24'd0, bus.address}, 32'd0);
        check("rst writedata", bus.writedata, 32'd0);
        check("rst byteenable", {28'd0, bus.byteenable}, 32'd0);
        check("rst state", {29'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic copy 0..3 -> 16..19
        for (int i = 0; i < 4; i++) preload(i, 32'h11111111 * (i + 1));
        b_done = n_done;
        b_busy = n_busy;
        pulse_start(0, 16, 4);
        check("basic rd_req read", {31'd0, bus.read}, 32'd1);
        check("basic rd_req addr", {24'd0, bus.address}, 32'd0);
        wait_done("basic");
        check("basic busy cycles", n_busy - b_busy, 32'd12);
        check("basic words_done", {23'd0, words_done}, 32'd4);
        check("basic done addr", {24'd0, bus.address}, 32'd0);
        tick();
        check("basic done pulses", n_done - b_done, 32'd1);
        check("basic done low", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) check("basic dst word", mem[16 + i], 32'h11111111 * (i + 1));

        // Zero length
        b_rd = n_rd;
        b_wr = n_wr;
        b_done = n_done;
        pulse_start(5, 6, 0);
        check("zero done", {31'd0, done}, 32'd1);
        check("zero busy", {31'd0, busy}, 32'd0);
        tick();
        check("zero done once", n_done - b_done, 32'd1);
        check("zero state idle", {29'd0, state_dbg}, 32'd0);
        check("zero reads", n_rd - b_rd, 32'd0);
        check("zero writes", n_wr - b_wr, 32'd0);

        // waitrequest stall on the first read
        preload(40, 32'hCAFE0040);
        preload(41, 32'hCAFE0041);
        b_rd = n_rd;
        stall_set = stall_used + 3;
        pulse_start(40, 50, 2);
        for (int i = 0; i < 3; i++) begin
            check("stall read held", {31'd0, bus.read}, 32'd1);
            check("stall addr held", {24'd0, bus.address}, 32'd40);
            check("stall waitrequest", {31'd0, bus.waitrequest}, 32'd1);
            tick();
        end
        check("stall released", {31'd0, bus.read & ~bus.waitrequest}, 32'd1);
        wait_done("stall");
        tick();
        check("stall reads", n_rd - b_rd, 32'd2);
        check("stall dst 50", mem[50], 32'hCAFE0040);
        check("stall dst 51", mem[51], 32'hCAFE0041);

        // Address wrap 254,255,0,1 -> 10..13
        preload(254, 32'hA0000254);
        preload(255, 32'hA0000255);
        preload(0, 32'hA0000000);
        preload(1, 32'hA0000001);
        pulse_start(254, 10, 4);
        wait_done("wrap");
        tick();
        check("wrap dst 10", mem[10], 32'hA0000254);
        check("wrap dst 11", mem[11], 32'hA0000255);
        check("wrap dst 12", mem[12], 32'hA0000000);
        check("wrap dst 13", mem[13], 32'hA0000001);

        // Start while busy must be ignored
        for (int i = 0; i < 3; i++) preload(100 + i, 32'hB0000100 + i);
        preload(200, 32'h5EA1F00D);
        b_done = n_done;
        pulse_start(100, 110, 3);
        for (int i = 0; i < 4; i++) tick();
        pulse_start(0, 200, 1);
        wait_done("busy start");
        check("busy start words_done", {23'd0, words_done}, 32'd3);
        for (int i = 0; i < 4; i++) tick();
        check("busy start one done", n_done - b_done, 32'd1);
        check("busy start idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) check("busy start dst", mem[110 + i], 32'hB0000100 + i);
        check("busy start no stray", mem[200], 32'h5EA1F00D);

        // Reset during WR_REQ of word 2 of 8
        for (int i = 0; i < 8; i++) preload(120 + i, 32'hC0000120 + i);
        pulse_start(120, 130, 8);
        n = 0;
        while (!(bus.write === 1'b1 && words_done === 9'd1) && n < 50) begin
            tick();
            n++;
        end
        check("midrst reached wr2", {31'd0, bus.write}, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst read", {31'd0, bus.read}, 32'd0);
        check("midrst write", {31'd0, bus.write}, 32'd0);
        check("midrst words_done", {23'd0, words_done}, 32'd0);
        check("midrst address", {24'd0, bus.address}, 32'd0);
        check("midrst writedata", bus.writedata, 32'd0);
        reset = 1'b0;
        b_rd = n_rd;
        b_wr = n_wr;
        b_done = n_done;
        for (int i = 0; i < 6; i++) tick();
        check("midrst no reads", n_rd - b_rd, 32'd0);
        check("midrst no writes", n_wr - b_wr, 32'd0);
        check("midrst no done", n_done - b_done, 32'd0);
        pulse_start(120, 140, 8);
        wait_done("after rst");
        check("after rst words_done", {23'd0, words_done}, 32'd8);
        tick();
        for (int i = 0; i < 8; i++) check("after rst dst", mem[140 + i], 32'hC0000120 + i);

        check("never read and write", n_both, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
